// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Turns the binary spike train of the network output neuron back into a
// number. A start pulse launches a measurement window of WINDOW clock cycles.
// During the window every rising edge of the spike input is counted (a spike
// held high for several cycles counts once). At the end of the window the
// count, a threshold decision and a saturation flag are latched and offered
// to the host side through a valid/ready handshake.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   spike         in   neuron_out spike train
//   start         in   launch a window (accepted in IDLE, or in DONE together
//                      with the result handshake for back-to-back windows)
//   busy          out  high while a window is being counted
//   result_valid  out  latched result is available
//   result_ready  in   consumer accepts the result
//   spike_count   out  rising edges counted in the last completed window
//   decision      out  1 when spike_count >= THRESHOLD
//   saturated     out  the count reached its maximum during the window
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int WINDOW    = 7168,
    parameter int WIN_WIDTH = 13,
    parameter int CNT_WIDTH = 10,
    parameter int THRESHOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spike,
    input  logic                 start,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CNT_WIDTH-1:0] spike_count,
    output logic                 decision,
    output logic                 saturated
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [WIN_WIDTH-1:0] LAST_IDX = WIN_WIDTH'(WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Saturating increment of the running count.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 en
    );
        if (en && (value != CNT_MAX)) begin
            return value + CNT_WIDTH'(1);
        end else begin
            return value;
        end
    endfunction

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_launch;
    logic                   r_spike_d;
    logic [WIN_WIDTH-1:0]   r_win_cnt;
    logic [CNT_WIDTH-1:0]   r_run_cnt;
    logic                   r_run_sat;
    logic                   r_busy;
    logic                   r_valid;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_decision;
    logic                   r_saturated;

    logic                   w_edge;
    logic                   w_last;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic                   w_sat_hit;

    assign w_edge    = spike & ~r_spike_d;
    assign w_last    = (r_win_cnt == LAST_IDX);
    assign w_cnt_inc = sat_inc(r_run_cnt, w_edge);
    // The count reaches its ceiling on this edge (or an edge arrives while
    // already pinned there).
    assign w_sat_hit = w_edge && (r_run_cnt >= (CNT_MAX - CNT_WIDTH'(1)));

    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign spike_count  = r_count;
    assign decision     = r_decision;
    assign saturated    = r_saturated;

    // Next-state logic; w_launch marks the cycle a new window is accepted.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_COUNT;
                    w_launch     = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_COUNT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_COUNT;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    if (start) begin
                        w_state_next = S_COUNT;
                        w_launch     = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Delayed spike for edge detection; runs in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spike_d <= 1'b0;
        end else begin
            r_spike_d <= spike;
        end
    end

    // Window counter and running count. The window counter stops at its last
    // index rather than incrementing, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= '0;
            r_run_cnt <= '0;
            r_run_sat <= 1'b0;
        end else if (w_launch) begin
            r_win_cnt <= '0;
            r_run_cnt <= '0;
            r_run_sat <= 1'b0;
        end else if (r_state == S_COUNT) begin
            r_run_cnt <= w_cnt_inc;
            r_run_sat <= r_run_sat | w_sat_hit;
            if (!w_last) begin
                r_win_cnt <= r_win_cnt + WIN_WIDTH'(1);
            end else begin
                r_win_cnt <= r_win_cnt;
            end
        end else begin
            r_win_cnt <= r_win_cnt;
            r_run_cnt <= r_run_cnt;
            r_run_sat <= r_run_sat;
        end
    end

    // Registered status flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_busy  <= (w_state_next == S_COUNT);
            r_valid <= (w_state_next == S_DONE);
        end
    end

    // Result registers: loaded only on the last window cycle, including that
    // cycle's edge, and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_decision  <= 1'b0;
            r_saturated <= 1'b0;
        end else if ((r_state == S_COUNT) && w_last) begin
            r_count     <= w_cnt_inc;
            r_decision  <= (int'(w_cnt_inc) >= THRESHOLD);
            r_saturated <= r_run_sat | w_sat_hit;
        end else begin
            r_count     <= r_count;
            r_decision  <= r_decision;
            r_saturated <= r_saturated;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// Bench for spike_rate_decoder. Five instances with different parameter sets
// each get their own stimulus; a window-level model per instance predicts the
// outputs, and one compare process checks every instance every cycle. Directed
// sequences add hand-computed literal expectations.
//   inst 0: WINDOW 7168, CNT 10, TH 16
//   inst 1: WINDOW 64,   CNT 10, TH 16
//   inst 2: WINDOW 64,   CNT 4,  TH 10
//   inst 3: WINDOW 16,   CNT 10, TH 16
//   inst 4: WINDOW 1,    CNT 10, TH 16
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    localparam int N = 5;

    logic clk;
    logic [N-1:0] rs, sp, st, rdy;
    logic [N-1:0] busy_v, val_v, dec_v, sat_v;
    logic [9:0]   cnt_v [N];
    logic [N-1:0] eb, ev, ed, es;
    logic [9:0]   ec [N];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_on   = 1'b0;
    int  cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < N; k++) begin : g
        localparam int W    = (k == 0) ? 7168 : (k == 3) ? 16 : (k == 4) ? 1 : 64;
        localparam int WW   = (k == 0) ? 13 : (k == 3) ? 4 : (k == 4) ? 1 : 6;
        localparam int CW   = (k == 2) ? 4 : 10;
        localparam int TH   = (k == 2) ? 10 : 16;
        localparam int MAXC = (1 << CW) - 1;

        logic          d_busy, d_valid, d_dec, d_sat;
        logic [CW-1:0] d_cnt;

        spike_rate_decoder #(
            .WINDOW(W), .WIN_WIDTH(WW), .CNT_WIDTH(CW), .THRESHOLD(TH)
        ) u_dut (
            .clk(clk), .rst(rs[k]), .spike(sp[k]), .start(st[k]),
            .busy(d_busy), .result_valid(d_valid), .result_ready(rdy[k]),
            .spike_count(d_cnt), .decision(d_dec), .saturated(d_sat)
        );

        // Window model: phase 0 idle, 1 counting, 2 result pending.
        int m_phase = 0;
        int m_left  = 0;
        int m_edges = 0;
        int m_count = 0;
        bit m_prev  = 1'b0;
        bit m_dec   = 1'b0;
        bit m_sat   = 1'b0;
        int m_e;
        int m_cap;

        assign m_e   = m_edges + ((sp[k] && !m_prev) ? 1 : 0);
        assign m_cap = (m_e > MAXC) ? MAXC : m_e;

        // Model update on each clock edge.
        always @(posedge clk) begin
            m_prev <= rs[k] ? 1'b0 : sp[k];
            if (rs[k]) begin
                m_phase <= 0; m_left <= 0; m_edges <= 0;
                m_count <= 0; m_dec <= 1'b0; m_sat <= 1'b0;
            end else begin
                case (m_phase)
                    0: if (st[k]) begin m_phase <= 1; m_left <= W; m_edges <= 0; end
                    1: if (m_left == 1) begin
                           m_phase <= 2;
                           m_count <= m_cap;
                           m_dec   <= (m_cap >= TH);
                           m_sat   <= (m_e >= MAXC);
                       end else begin
                           m_edges <= m_e;
                           m_left  <= m_left - 1;
                       end
                    2: if (rdy[k]) begin
                           if (st[k]) begin m_phase <= 1; m_left <= W; m_edges <= 0; end
                           else m_phase <= 0;
                       end
                    default: m_phase <= 0;
                endcase
            end
        end

        assign busy_v[k] = d_busy;
        assign val_v[k]  = d_valid;
        assign dec_v[k]  = d_dec;
        assign sat_v[k]  = d_sat;
        assign cnt_v[k]  = 10'(d_cnt);
        assign eb[k]     = (m_phase == 1);
        assign ev[k]     = (m_phase == 2);
        assign ed[k]     = m_dec;
        assign es[k]     = m_sat;
        assign ec[k]     = 10'(m_count);
    end

    // Compare process: every instance, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < N; k++) begin
                chk("busy",  k, int'(busy_v[k]), int'(eb[k]));
                chk("valid", k, int'(val_v[k]),  int'(ev[k]));
                chk("count", k, int'(cnt_v[k]),  int'(ec[k]));
                chk("dec",   k, int'(dec_v[k]),  int'(ed[k]));
                chk("sat",   k, int'(sat_v[k]),  int'(es[k]));
            end
        end
    end

    task automatic accept(input int k);
        rdy[k] = 1'b1;
        @(negedge clk);
        rdy[k] = 1'b0;
        chk("acc_valid", k, int'(val_v[k]), 0);
    endtask

    task automatic check_result(input string name, input int k, input int c, input int d, input int s);
        chk({name, "_valid"}, k, int'(val_v[k]), 1);
        chk({name, "_count"}, k, int'(cnt_v[k]), c);
        chk({name, "_dec"},   k, int'(dec_v[k]), d);
        chk({name, "_sat"},   k, int'(sat_v[k]), s);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rs = '1; sp = '0; st = '0; rdy = '0;
        repeat (3) @(negedge clk);
        rs = '0;
        @(negedge clk);
        chk_on = 1'b1;
        for (int k = 0; k < N; k++) begin
            chk("rst_busy",  k, int'(busy_v[k]), 0);
            chk("rst_valid", k, int'(val_v[k]),  0);
            chk("rst_count", k, int'(cnt_v[k]),  0);
        end

        // Test 1: full-length window, no spikes; valid WINDOW+1 cycles later.
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        lat = 1;
        while (!val_v[0] && lat < 7300) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", 0, lat, 7169);
        check_result("t1", 0, 0, 0, 0);
        accept(0);

        // Test 2: 3 high / 5 low, first rise on first COUNT cycle -> 8 edges.
        st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sp[1] = ((i % 8) < 3);
            @(negedge clk);
        end
        sp[1] = 1'b0;
        check_result("t2", 1, 8, 0, 0);

        // Test 4: result held while ready is low; start pulses ignored.
        for (int i = 0; i < 20; i++) begin
            st[1] = ((i % 5) == 2);
            @(negedge clk);
            chk("t4_hold_valid", 1, int'(val_v[1]), 1);
            chk("t4_hold_count", 1, int'(cnt_v[1]), 8);
        end
        st[1] = 1'b1;
        rdy[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        rdy[1] = 1'b0;
        chk("t4_busy", 1, int'(busy_v[1]), 1);
        chk("t4_valid_low", 1, int'(val_v[1]), 0);
        for (int i = 0; i < 64; i++) begin
            sp[1] = ((i % 2) == 0);
            @(negedge clk);
            if (i == 62) chk("t4_not_yet", 1, int'(val_v[1]), 0);
        end
        sp[1] = 1'b0;
        check_result("t4", 1, 32, 1, 0);
        accept(1);

        // Test 3: toggling every cycle into a 4-bit count -> saturates at 15.
        st[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sp[2] = ((i % 2) == 0);
            @(negedge clk);
        end
        sp[2] = 1'b0;
        check_result("t3", 2, 15, 1, 1);
        accept(2);

        // Test 5a: spike high before start and held -> 0.
        sp[3] = 1'b1;
        repeat (2) @(negedge clk);
        st[3] = 1'b1;
        @(negedge clk);
        st[3] = 1'b0;
        repeat (16) @(negedge clk);
        check_result("t5a", 3, 0, 0, 0);
        accept(3);
        sp[3] = 1'b0;
        // Test 5b: the only edge is in the start cycle -> 0.
        repeat (3) @(negedge clk);
        sp[3] = 1'b1;
        st[3] = 1'b1;
        @(negedge clk);
        st[3] = 1'b0;
        repeat (16) @(negedge clk);
        check_result("t5b", 3, 0, 0, 0);
        accept(3);
        sp[3] = 1'b0;
        // Test 5c: one edge on the last COUNT cycle -> 1.
        repeat (3) @(negedge clk);
        st[3] = 1'b1;
        @(negedge clk);
        st[3] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sp[3] = (i == 15);
            @(negedge clk);
        end
        sp[3] = 1'b0;
        check_result("t5c", 3, 1, 0, 0);
        accept(3);

        // Test 6: reset at window cycle 30 discards the window.
        st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sp[1] = ((i % 2) == 0);
            @(negedge clk);
        end
        rs[1] = 1'b1;
        @(negedge clk);
        rs[1] = 1'b0;
        chk("t6_busy",  1, int'(busy_v[1]), 0);
        chk("t6_valid", 1, int'(val_v[1]),  0);
        chk("t6_count", 1, int'(cnt_v[1]),  0);
        for (int i = 0; i < 100; i++) begin
            sp[1] = ((i % 2) == 0);
            @(negedge clk);
            chk("t6_no_valid", 1, int'(val_v[1]), 0);
        end
        sp[1] = 1'b0;

        // WINDOW = 1: one COUNT cycle, valid at t+2.
        st[4] = 1'b1;
        @(negedge clk);
        st[4] = 1'b0;
        sp[4] = 1'b1;
        chk("w1_busy", 4, int'(busy_v[4]), 1);
        chk("w1_valid_early", 4, int'(val_v[4]), 0);
        @(negedge clk);
        sp[4] = 1'b0;
        check_result("w1", 4, 1, 0, 0);
        // Back-to-back window from DONE.
        st[4] = 1'b1;
        rdy[4] = 1'b1;
        @(negedge clk);
        st[4] = 1'b0;
        rdy[4] = 1'b0;
        chk("w1_b2b_busy", 4, int'(busy_v[4]), 1);
        @(negedge clk);
        check_result("w1_b2b", 4, 0, 0, 0);
        accept(4);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
